remote_comm: RTL

- Host-side command initiator; the other end of the quadcopter's 3-byte command link.
- Accepts an 8-bit cmd and a 16-bit data word from a host/test harness.
- Serializes them over UART as cmd, data[15:8], data[7:0], then waits for a 1-byte response from the airframe.
- Reuses the team's existing UART_tx and UART_rcv. This block is the frame sequencer plus the response/timeout logic.

---
 rtl/remote_comm_pkg.sv | 14 +
 rtl/UART_rcv.sv | 66 ++++++
 rtl/UART_tx.sv | 52 +++++
 rtl/remote_comm.sv | 132 +++++++++++++
 4 files changed

// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the host-side command initiator.
package remote_comm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_RESP
  } state_t;

  localparam int         BYTES_PER_FRAME  = 3;
  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;

endpackage

// File: rtl/UART_rcv.sv
// 8N1 UART receiver. rdy rises with rx_data valid at mid stop bit; clr_rdy
// clears it and takes priority over a byte completing in the same cycle.
module UART_rcv #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  logic        rx_ff1, rx_ff2;
  logic        receiving;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic        byte_done;

  assign byte_done = receiving && (baud_cnt == 16'd0) && (bit_cnt == 4'd8);

  // Double-flop synchroniser; reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_ff2 <= 1'b1;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
    end
  end

  // Bit sampler: first sample 1.5 bit times after the start edge, then one per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      receiving <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
    end else if (!receiving) begin
      if (!rx_ff2) begin
        receiving <= 1'b1;
        baud_cnt  <= 16'(BAUD_DIV + BAUD_DIV / 2 - 1);
        bit_cnt   <= '0;
      end
    end else if (baud_cnt == 16'd0) begin
      baud_cnt <= 16'(BAUD_DIV - 1);
      if (bit_cnt == 4'd8) begin
        receiving <= 1'b0;
      end else begin
        rx_data <= {rx_ff2, rx_data[7:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  // Ready flag: set when the stop bit is reached, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rdy <= 1'b0;
    else if (clr_rdy)   rdy <= 1'b0;
    else if (byte_done) rdy <= 1'b1;
  end

endmodule

// File: rtl/UART_tx.sv
// 8N1 UART transmitter. trmt loads a byte; tx_done rises after the stop bit
// and stays high until the next trmt.
module UART_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  logic [9:0]  shift_reg;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic        shifting;

  // Frame shifter: start bit, 8 data bits LSB first, stop bit; line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shifting  <= 1'b0;
      tx_done   <= 1'b0;
    end else if (trmt) begin
      shift_reg <= {1'b1, tx_data, 1'b0};
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shifting  <= 1'b1;
      tx_done   <= 1'b0;
    end else if (shifting) begin
      if (baud_cnt == 16'(BAUD_DIV - 1)) begin
        baud_cnt  <= '0;
        shift_reg <= {1'b1, shift_reg[9:1]};
        if (bit_cnt == 4'd9) begin
          shifting <= 1'b0;
          tx_done  <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  assign TX = shift_reg[0];

endmodule

// File: rtl/remote_comm.sv
// Host-side command initiator: sends cmd, data[15:8], data[7:0] over UART and
// then waits for a one-byte response from the airframe, or times out.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter logic [21:0] TIMEOUT_CLKS = 22'd2_500_000,
  parameter logic [7:0]  ACK_BYTE     = DEFAULT_ACK_BYTE,
  parameter int          BAUD_DIV     = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        TX,
  input  logic        RX,
  output logic        busy,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        ack,
  output logic        timeout
);

  state_t      state;
  logic [23:0] shadow;
  logic [1:0]  byte_idx;
  logic [21:0] to_cnt;
  logic        trmt;
  logic        clr_rdy;
  logic        tx_done;
  logic        rdy;
  logic [7:0]  rx_data;
  logic        accept;
  logic        byte_done;

  assign accept    = (state == IDLE) && snd_cmd;
  // trmt is still high on the first WAIT_TX cycle, when tx_done may be the
  // stale flag of the previous byte; ignore it until UART_tx has taken trmt.
  assign byte_done = (state == WAIT_TX) && tx_done && !trmt;
  assign busy      = (state != IDLE);

  // Sequencer. clr_rdy is held high everywhere except WAIT_RESP so that any
  // byte completing before the frame has gone out is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_idx <= '0;
      to_cnt   <= '0;
      trmt     <= 1'b0;
      clr_rdy  <= 1'b0;
      cmd_sent <= 1'b0;
      resp_rdy <= 1'b0;
      resp     <= 8'h00;
      ack      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      trmt    <= 1'b0;
      clr_rdy <= 1'b0;
      case (state)
        IDLE: begin
          clr_rdy <= 1'b1;
          if (snd_cmd) begin
            cmd_sent <= 1'b0;
            resp_rdy <= 1'b0;
            timeout  <= 1'b0;
            byte_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          trmt    <= 1'b1;
          clr_rdy <= 1'b1;
          state   <= WAIT_TX;
        end
        WAIT_TX: begin
          clr_rdy <= 1'b1;
          if (byte_done) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'(BYTES_PER_FRAME - 1)) begin
              cmd_sent <= 1'b1;
              to_cnt   <= '0;
              clr_rdy  <= 1'b0;
              state    <= WAIT_RESP;
            end else begin
              state <= SEND;
            end
          end
        end
        WAIT_RESP: begin
          to_cnt <= to_cnt + 22'd1;
          if (rdy) begin
            resp     <= rx_data;
            ack      <= (rx_data == ACK_BYTE);
            resp_rdy <= 1'b1;
            clr_rdy  <= 1'b1;
            state    <= IDLE;
          end else if (to_cnt == TIMEOUT_CLKS - 22'd1) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame shadow: loaded on acceptance, shifted as each byte completes.
  always_ff @(posedge clk) begin
    if (accept)         shadow <= {cmd, data};
    else if (byte_done) shadow <= {shadow[15:0], 8'h00};
  end

  UART_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt),
    .tx_data(shadow[23:16]),
    .TX     (TX),
    .tx_done(tx_done)
  );

  UART_rcv #(.BAUD_DIV(BAUD_DIV)) u_rcv (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy)
  );

endmodule
